// File: rtl/mux_slot_decoder.sv
// mux_slot_decoder: rebuilds a frame of NUM_INPUTS channels from time-multiplexed slots framed by a marker cycle.
module mux_slot_decoder #(
  parameter int MUX_LINES  = 4,
  parameter int NUM_LINES  = 2,
  parameter int NUM_INPUTS = NUM_LINES * MUX_LINES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [MUX_LINES:0]    mux_in,
  input  logic                  sh_reset_in,
  input  logic [NUM_LINES-1:0]  line_in,
  output logic [NUM_INPUTS-1:0] pulse_out,
  output logic                  frame_valid,
  output logic                  locked,
  output logic                  error,
  output logic [31:0]           frame_count,
  output logic [15:0]           err_count
);
  localparam int SW = MUX_LINES > 1 ? $clog2(MUX_LINES) : 1;
  typedef enum logic [1:0] {HUNT, SLOT, MARK} state_t;
  state_t state, state_nx;
  logic [SW-1:0] slot, slot_nx;
  logic [MUX_LINES-1:0][NUM_LINES-1:0] shadow;
  logic [MUX_LINES:0] exp_sel;
  logic marker, slot_ok, last, capture, commit, viol;
  // Anything in SLOT/MARK that is neither a capture nor a commit is a violation,
  // so a marker that collides with a violation can never resynchronise.
  always_comb begin
    exp_sel  = {{MUX_LINES{1'b0}}, 1'b1} << slot;
    marker   = sh_reset_in && mux_in == '0;
    slot_ok  = !sh_reset_in && mux_in == exp_sel;
    last     = slot == SW'(MUX_LINES - 1);
    capture  = enable && state == SLOT && slot_ok;
    commit   = enable && state == MARK && marker;
    viol     = enable && state != HUNT && !capture && !commit;
    state_nx = state;
    slot_nx  = slot;
    if (!enable || viol) begin
      state_nx = HUNT;
      slot_nx  = '0;
    end else if (state == HUNT && marker) begin
      state_nx = SLOT;
      slot_nx  = '0;
    end else if (capture) begin
      state_nx = last ? MARK : SLOT;
      slot_nx  = last ? '0 : slot + 1'b1;
    end else if (commit) begin
      state_nx = SLOT;
      slot_nx  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      slot        <= '0;
      shadow      <= '0;
      pulse_out   <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      error       <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_nx;
      slot        <= slot_nx;
      frame_valid <= commit;
      error       <= viol;
      locked      <= commit ? 1'b1 : (viol || !enable) ? 1'b0 : locked;
      if (capture) shadow[slot] <= line_in;
      else if (viol) shadow <= '0;
      if (commit) begin
        pulse_out   <= shadow;
        frame_count <= frame_count + 32'd1;
      end
      if (viol && err_count != '1) err_count <= err_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_mux_slot_decoder.sv
// tb_mux_slot_decoder: scoreboard bench for mux_slot_decoder with MUX_LINES=4, NUM_LINES=2.
module tb_mux_slot_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [4:0] mux_in = '0;
  logic sh_reset_in = 1'b0;
  logic [1:0] line_in = '0;
  logic [7:0] pulse_out;
  logic frame_valid, locked, error;
  logic [31:0] frame_count;
  logic [15:0] err_count;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_fv_cyc = 0;
  logic [7:0] last_commit = '0;
  logic [7:0] sb[$];

  mux_slot_decoder dut (
    .clk(clk), .reset(reset), .enable(enable), .mux_in(mux_in),
    .sh_reset_in(sh_reset_in), .line_in(line_in), .pulse_out(pulse_out),
    .frame_valid(frame_valid), .locked(locked), .error(error),
    .frame_count(frame_count), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      logic [7:0] exp;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected_commit: pulse_out=%h but no commit expected", pulse_out);
      end else begin
        exp = sb.pop_front();
        if (pulse_out !== exp) begin mismatched++; $display("FAIL sb_pulse_out: got %h want %h", pulse_out, exp); end
      end
      compared++;
      if (error !== 1'b0) begin mismatched++; $display("FAIL fv_error_overlap: error=%b with frame_valid", error); end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic e, input logic [4:0] m, input logic s, input logic [1:0] l);
    enable = e; mux_in = m; sh_reset_in = s; line_in = l;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_slots(input logic [7:0] d, input logic e);
    for (int s = 0; s < 4; s++) step(e, 5'(1 << s), 1'b0, d[2*s +: 2]);
  endtask

  task automatic marker_only();
    step(1'b1, 5'b0, 1'b1, 2'b0);
  endtask

  task automatic commit_marker(input logic [7:0] d);
    sb.push_back(d);
    step(1'b1, 5'b0, 1'b1, 2'b0);
    last_commit = d;
    compared++;
    if (frame_valid !== 1'b1) begin mismatched++; $display("FAIL commit_fv: got %b want 1", frame_valid); end
    else last_fv_cyc = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 5'b0, 1'b0, 2'b0);
    reset = 1'b0;
    last_commit = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 5'b0, 1'b0, 2'b0);
    step(1'b1, 5'b0, 1'b1, 2'b0);
    compared += 6;
    if (pulse_out !== 8'h00) begin mismatched++; $display("FAIL reset_pulse_out: got %h want 00", pulse_out); end
    if (frame_valid !== 1'b0) begin mismatched++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    if (locked !== 1'b0) begin mismatched++; $display("FAIL reset_locked: got %b want 0", locked); end
    if (error !== 1'b0) begin mismatched++; $display("FAIL reset_error: got %b want 0", error); end
    if (frame_count !== 32'd0) begin mismatched++; $display("FAIL reset_fc: got %0d want 0", frame_count); end
    if (err_count !== 16'd0) begin mismatched++; $display("FAIL reset_ec: got %0d want 0", err_count); end
    reset = 1'b0;
  endtask

  task automatic test_basic_frame();
    marker_only();
    send_slots(8'b00111001, 1'b1);
    compared += 2;
    if (frame_valid !== 1'b0) begin mismatched++; $display("FAIL basic_early_fv: got %b want 0", frame_valid); end
    if (pulse_out !== 8'h00) begin mismatched++; $display("FAIL basic_early_pulse: got %h want 00", pulse_out); end
    commit_marker(8'b00111001);
    compared += 4;
    if (pulse_out !== 8'b00111001) begin mismatched++; $display("FAIL basic_pulse_out: got %b want 00111001", pulse_out); end
    if (locked !== 1'b1) begin mismatched++; $display("FAIL basic_locked: got %b want 1", locked); end
    if (frame_count !== 32'd1) begin mismatched++; $display("FAIL basic_fc: got %0d want 1", frame_count); end
    if (error !== 1'b0) begin mismatched++; $display("FAIL basic_error: got %b want 0", error); end
  endtask

  task automatic test_back_to_back();
    int prev;
    logic [7:0] d;
    do_reset();
    marker_only();
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      send_slots(d, 1'b1);
      commit_marker(d);
      if (i > 0) begin
        compared++;
        if (last_fv_cyc - prev !== 5) begin mismatched++; $display("FAIL b2b_spacing: got %0d want 5", last_fv_cyc - prev); end
      end
      prev = last_fv_cyc;
    end
    compared += 3;
    if (frame_count !== 32'd3) begin mismatched++; $display("FAIL b2b_fc: got %0d want 3", frame_count); end
    if (err_count !== 16'd0) begin mismatched++; $display("FAIL b2b_ec: got %0d want 0", err_count); end
    if (locked !== 1'b1) begin mismatched++; $display("FAIL b2b_locked: got %b want 1", locked); end
  endtask

  task automatic test_slot_error();
    step(1'b1, 5'b00100, 1'b0, 2'b11);
    compared += 5;
    if (error !== 1'b1) begin mismatched++; $display("FAIL slot_err_error: got %b want 1", error); end
    if (err_count !== 16'd1) begin mismatched++; $display("FAIL slot_err_ec: got %0d want 1", err_count); end
    if (locked !== 1'b0) begin mismatched++; $display("FAIL slot_err_locked: got %b want 0", locked); end
    if (pulse_out !== last_commit) begin mismatched++; $display("FAIL slot_err_pulse: got %h want %h", pulse_out, last_commit); end
    if (frame_valid !== 1'b0) begin mismatched++; $display("FAIL slot_err_fv: got %b want 0", frame_valid); end
    step(1'b1, 5'b00001, 1'b0, 2'b01);
    compared++;
    if (error !== 1'b0) begin mismatched++; $display("FAIL slot_err_hunt_quiet: got %b want 0", error); end
    marker_only();
    send_slots(8'hA5, 1'b1);
    commit_marker(8'hA5);
    compared += 2;
    if (frame_count !== 32'd4) begin mismatched++; $display("FAIL slot_err_resync_fc: got %0d want 4", frame_count); end
    if (locked !== 1'b1) begin mismatched++; $display("FAIL slot_err_resync_locked: got %b want 1", locked); end
  endtask

  task automatic test_mark_error();
    send_slots(8'h5A, 1'b1);
    step(1'b1, 5'b00001, 1'b1, 2'b00);
    compared += 5;
    if (error !== 1'b1) begin mismatched++; $display("FAIL mark_err_error: got %b want 1", error); end
    if (frame_valid !== 1'b0) begin mismatched++; $display("FAIL mark_err_fv: got %b want 0", frame_valid); end
    if (pulse_out !== 8'hA5) begin mismatched++; $display("FAIL mark_err_pulse: got %h want a5", pulse_out); end
    if (err_count !== 16'd2) begin mismatched++; $display("FAIL mark_err_ec: got %0d want 2", err_count); end
    if (frame_count !== 32'd4) begin mismatched++; $display("FAIL mark_err_fc: got %0d want 4", frame_count); end
    marker_only();
    send_slots(8'hC3, 1'b1);
    commit_marker(8'hC3);
    compared++;
    if (frame_count !== 32'd5) begin mismatched++; $display("FAIL mark_err_resync_fc: got %0d want 5", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    step(1'b1, 5'b00001, 1'b0, 2'b10);
    step(1'b1, 5'b00010, 1'b0, 2'b01);
    reset = 1'b1;
    step(1'b1, 5'b00100, 1'b0, 2'b11);
    reset = 1'b0;
    last_commit = '0;
    compared += 6;
    if (pulse_out !== 8'h00) begin mismatched++; $display("FAIL midrst_pulse: got %h want 00", pulse_out); end
    if (frame_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_fv: got %b want 0", frame_valid); end
    if (locked !== 1'b0) begin mismatched++; $display("FAIL midrst_locked: got %b want 0", locked); end
    if (error !== 1'b0) begin mismatched++; $display("FAIL midrst_error: got %b want 0", error); end
    if (frame_count !== 32'd0) begin mismatched++; $display("FAIL midrst_fc: got %0d want 0", frame_count); end
    if (err_count !== 16'd0) begin mismatched++; $display("FAIL midrst_ec: got %0d want 0", err_count); end
  endtask

  task automatic test_enable_off();
    marker_only();
    send_slots(8'h96, 1'b1);
    commit_marker(8'h96);
    for (int f = 0; f < 10; f++) begin
      step(1'b0, 5'b0, 1'b1, 2'b0);
      compared += 2;
      if (locked !== 1'b0) begin mismatched++; $display("FAIL en_off_locked: got %b want 0", locked); end
      if (error !== 1'b0) begin mismatched++; $display("FAIL en_off_error: got %b want 0", error); end
      send_slots(8'($urandom), 1'b0);
      compared += 3;
      if (frame_count !== 32'd1) begin mismatched++; $display("FAIL en_off_fc: got %0d want 1", frame_count); end
      if (err_count !== 16'd0) begin mismatched++; $display("FAIL en_off_ec: got %0d want 0", err_count); end
      if (pulse_out !== 8'h96) begin mismatched++; $display("FAIL en_off_pulse: got %h want 96", pulse_out); end
    end
    marker_only();
    send_slots(8'h3C, 1'b1);
    commit_marker(8'h3C);
    compared++;
    if (frame_count !== 32'd2) begin mismatched++; $display("FAIL en_on_fc: got %0d want 2", frame_count); end
  endtask

  task automatic test_err_saturate();
    force dut.err_count = 16'hFFFE;
    #1 release dut.err_count;
    step(1'b1, 5'b00010, 1'b0, 2'b00);
    compared += 2;
    if (error !== 1'b1) begin mismatched++; $display("FAIL sat_error1: got %b want 1", error); end
    if (err_count !== 16'hFFFF) begin mismatched++; $display("FAIL sat_ec1: got %h want ffff", err_count); end
    marker_only();
    step(1'b1, 5'b10000, 1'b0, 2'b00);
    compared += 2;
    if (error !== 1'b1) begin mismatched++; $display("FAIL sat_error2: got %b want 1", error); end
    if (err_count !== 16'hFFFF) begin mismatched++; $display("FAIL sat_ec2: got %h want ffff", err_count); end
  endtask

  task automatic test_frame_wrap();
    force dut.frame_count = 32'hFFFFFFFF;
    #1 release dut.frame_count;
    marker_only();
    send_slots(8'hE7, 1'b1);
    compared++;
    if (frame_count !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL wrap_preload: got %h want ffffffff", frame_count); end
    commit_marker(8'hE7);
    compared += 2;
    if (frame_count !== 32'd0) begin mismatched++; $display("FAIL wrap_fc: got %h want 0", frame_count); end
    if (pulse_out !== 8'hE7) begin mismatched++; $display("FAIL wrap_pulse: got %h want e7", pulse_out); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_slot_error();
    test_mark_error();
    test_reset_mid_frame();
    test_enable_off();
    test_err_saturate();
    test_frame_wrap();
    @(posedge clk);
    compared++;
    if (sb.size() != 0) begin mismatched++; $display("FAIL sb_leftover: got %0d pending commits want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mux_slot_decoder.md
MUX_SLOT_DECODER -- requirements
Module: mux_slot_decoder

Interface
REQ-001 SHALL have parameter MUX_LINES, default 4, the number of time slots per frame.
REQ-002 SHALL have parameter NUM_LINES, default 2, the number of physical data lines per slot.
REQ-003 SHALL have parameter NUM_INPUTS, default NUM_LINES*MUX_LINES, the number of reconstructed channels.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: decoding enabled when high.
REQ-007 SHALL have port mux_in, input, MUX_LINES+1 bits: one-hot slot select; all-zero in the marker cycle.
REQ-008 SHALL have port sh_reset_in, input, 1 bit: frame marker, high only in the marker cycle.
REQ-009 SHALL have port line_in, input, NUM_LINES bits: slot data, valid in the same cycle as mux_in.
REQ-010 SHALL have port pulse_out, output, NUM_INPUTS bits: last committed frame; bit slot*NUM_LINES+x comes from line_in[x] in that slot.
REQ-011 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when pulse_out updates.
REQ-012 SHALL have port locked, output, 1 bit: high while frames decode without error.
REQ-013 SHALL have port error, output, 1 bit: one-cycle pulse on a protocol violation.
REQ-014 SHALL have port frame_count, output, 32 bits: count of committed frames, wrapping.
REQ-015 SHALL have port err_count, output, 16 bits: count of violations, saturating at 16'hFFFF.

Function
REQ-016 SHALL implement the states HUNT, SLOT and MARK, with a slot counter sized for 0..MUX_LINES-1.
REQ-017 In HUNT, it SHALL wait for sh_reset_in=1 with mux_in=0, then go to SLOT with slot=0; all other input combinations SHALL be ignored without flagging an error.
REQ-018 In SLOT, if mux_in equals 1<<slot and sh_reset_in=0, it SHALL capture line_in[x] into shadow[slot*NUM_LINES+x].
REQ-019 In SLOT, after a valid capture, it SHALL increment slot; after slot MUX_LINES-1 it SHALL go to MARK.
REQ-020 In MARK, if sh_reset_in=1 and mux_in=0, it SHALL copy shadow (including the final slot's data) to pulse_out, pulse frame_valid, increment frame_count, set locked, and go to SLOT with slot=0.
REQ-021 Commit latency SHALL be one cycle: pulse_out and frame_valid are visible the cycle after the marker is sampled.
REQ-022 A violation in SLOT or MARK SHALL pulse error, increment err_count (saturating), clear locked, discard shadow, and go to HUNT.
REQ-023 Violations SHALL be: mux_in not one-hot-equal to the expected slot; more than one mux_in bit set; mux_in[MUX_LINES] set; sh_reset_in=1 during SLOT; or, in MARK, anything other than sh_reset_in=1 with mux_in=0.
REQ-024 If sh_reset_in=1 and mux_in is non-zero in the same cycle in SLOT or MARK, this SHALL be a violation.
REQ-025 A violation cycle SHALL NOT also count as a marker, so resynchronisation needs the next clean marker.
REQ-026 pulse_out SHALL hold its last committed value through errors, HUNT and enable=0.
REQ-027 enable=0 SHALL force HUNT and clear locked, with no capture and no error; counters SHALL hold.
REQ-028 frame_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-029 frame_valid and error SHALL never be high in the same cycle.

Reset
REQ-030 On reset=1 at a clock edge, it SHALL set state=HUNT, slot=0, shadow=0, pulse_out=0, frame_valid=0, locked=0, error=0, frame_count=0, err_count=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame without counting an error; reset SHALL take priority over enable.

Verification
REQ-032 Bench SHALL cover, with MUX_LINES=4, NUM_LINES=2: marker, then slots 0-3 carrying line_in=01,10,11,00, then marker -> pulse_out=8'b00111001 and frame_valid one cycle after the second marker, locked=1, frame_count=1.
REQ-033 Bench SHALL cover: 3 back-to-back clean frames -> frame_count=3, no error, frame_valid spaced 5 cycles apart.
REQ-034 Bench SHALL cover: mux_in=00100 in slot 0 -> error pulse, err_count=1, locked=0, pulse_out unchanged; the next clean marker plus frame -> commit.
REQ-035 Bench SHALL cover: sh_reset_in=1 with mux_in=00001 in MARK -> error, and no commit.
REQ-036 Bench SHALL cover: reset asserted during slot 2 -> all outputs 0 next cycle, err_count=0; enable=0 for 10 frames -> no frame_valid, counters hold.
REQ-037 Bench SHALL cover: err_count preloaded to 16'hFFFF by forcing violations, then one more violation -> err_count stays 16'hFFFF; frame_count wraps from 32'hFFFFFFFF to 0 on a commit.
